// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared types and constants for the serial pattern transmitter.
//   tx_state_t          FSM state encoding (IDLE, SHIFT, PARITY, GAP, DONE)
//   OH_*                one-hot debug codes presented on state_oh
//   SEQ_TX_PAT_DEFAULT  built-in pattern sent when use_default=1
//   state_to_oh()       maps a state to its one-hot debug code
package seq_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } tx_state_t;

    localparam logic [4:0] OH_IDLE   = 5'b00001;
    localparam logic [4:0] OH_SHIFT  = 5'b00010;
    localparam logic [4:0] OH_PARITY = 5'b00100;
    localparam logic [4:0] OH_GAP    = 5'b01000;
    localparam logic [4:0] OH_DONE   = 5'b10000;

    localparam logic [4:0] SEQ_TX_PAT_DEFAULT = 5'b10110;

    function automatic logic [4:0] state_to_oh(input tx_state_t s);
        logic [4:0] oh;
        case (s)
            ST_IDLE:   oh = OH_IDLE;
            ST_SHIFT:  oh = OH_SHIFT;
            ST_PARITY: oh = OH_PARITY;
            ST_GAP:    oh = OH_GAP;
            ST_DONE:   oh = OH_DONE;
            default:   oh = OH_IDLE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: loadable left-shift register for the pattern transmitter.
//   clk, rstb    clock / asynchronous active-low reset
//   load         capture load_val (takes priority over shift_en)
//   shift_en     shift left by one, zero fill
//   load_val     PAT_W-bit pattern, MSB first
//   msb          current MSB of the register
//   parity       XOR of all bits of the last loaded pattern
// The MSB of load_val goes straight into the transmitter's ser_out register
// on the load edge, so the register stores the pattern already shifted once.
// That way msb always holds the bit to be sent on the following cycle.
module seq_tx_shreg #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             parity
);

    logic [PAT_W-1:0] shreg_reg;
    logic             parity_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shreg_reg  <= '0;
            parity_reg <= 1'b0;
        end else if (load) begin
            shreg_reg  <= {load_val[PAT_W-2:0], 1'b0};
            parity_reg <= ^load_val;
        end else if (shift_en) begin
            shreg_reg  <= {shreg_reg[PAT_W-2:0], 1'b0};
        end
    end

    assign msb    = shreg_reg[PAT_W-1];
    assign parity = parity_reg;

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter for the lab1 sequence-detector link.
// Latches a PAT_W-bit pattern on start and sends repeat_n+1 frames MSB-first,
// one bit per clock, with gap idle cycles between frames, then pulses done.
//   clk, rstb    clock (rising edge) / asynchronous active-low reset
//   start        request, sampled only in IDLE
//   use_default  1: send PAT_DEFAULT, 0: send pattern (sampled with start)
//   pattern      user pattern, MSB first
//   repeat_n     extra frames after the first
//   gap          idle cycles between frames
//   abort        synchronous cancel from any state, no done pulse
//   ser_out      serial data, 0 whenever ser_valid=0
//   ser_valid    ser_out carries a pattern/parity bit
//   busy         high in SHIFT, PARITY, GAP
//   done         one-cycle pulse after the final bit
//   state_oh     one-hot debug [0]IDLE [1]SHIFT [2]PARITY [3]GAP [4]DONE
// Build option: define SEQ_TX_PARITY_EN to append one even-parity bit to every
// frame. Without it the PARITY state is unreachable and state_oh[2] is tied 0.
// All outputs are registered from the next-state values, so they line up
// with the state register and carry no combinational decode.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = SEQ_TX_PAT_DEFAULT,
    parameter int               CNT_W       = 4,
    parameter int               GAP_W       = 3
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [4:0]       state_oh
);

    localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;

    tx_state_t        state_reg, state_next, frame_target;
    logic [PAT_W-1:0] pat_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [CNT_W-1:0] frames_left_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;

    logic             ser_out_reg, ser_valid_reg, busy_reg, done_reg;
    logic [4:0]       state_oh_reg;
    logic             ser_out_next, ser_valid_next, busy_next, done_next;
    logic [4:0]       state_oh_next;

    logic [PAT_W-1:0] load_val;
    logic             shreg_load, shreg_shift, shreg_msb, shreg_parity;
    logic             frame_end;

    // In IDLE the pattern comes straight from the inputs (it is being latched
    // on this very edge); afterwards reloads use the latched copy.
    assign load_val = (state_reg == ST_IDLE) ? (use_default ? PAT_DEFAULT : pattern)
                                             : pat_reg;

    // Any entry into SHIFT reloads the pattern, except staying inside a frame.
    assign shreg_load  = (state_next == ST_SHIFT) &&
                         !((state_reg == ST_SHIFT) && (bit_cnt_reg != '0));
    assign shreg_shift = (state_next == ST_SHIFT) && !shreg_load;

`ifdef SEQ_TX_PARITY_EN
    assign frame_end = (state_reg == ST_PARITY);
`else
    assign frame_end = (state_reg == ST_SHIFT) && (bit_cnt_reg == '0);
`endif

    seq_tx_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rstb     (rstb),
        .load     (shreg_load),
        .shift_en (shreg_shift),
        .load_val (load_val),
        .msb      (shreg_msb),
        .parity   (shreg_parity)
    );

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Where a finished frame goes next
    always_comb begin
        frame_target = ST_DONE;
        if (frames_left_reg != '0)
            frame_target = (gap_reg != '0) ? ST_GAP : ST_SHIFT;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt_reg == '0) begin
`ifdef SEQ_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = frame_target;
`endif
                end
            end
            ST_PARITY: state_next = frame_target;
            ST_GAP:    if (gap_cnt_reg == '0) state_next = ST_SHIFT;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    // Output logic, evaluated on the next state and registered below
    always_comb begin
        ser_out_next   = 1'b0;
        ser_valid_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        state_oh_next  = state_to_oh(state_next);
`ifndef SEQ_TX_PARITY_EN
        state_oh_next[2] = 1'b0;
`endif
        case (state_next)
            ST_SHIFT: begin
                ser_valid_next = 1'b1;
                busy_next      = 1'b1;
                ser_out_next   = shreg_load ? load_val[PAT_W-1] : shreg_msb;
            end
            ST_PARITY: begin
                ser_valid_next = 1'b1;
                busy_next      = 1'b1;
                ser_out_next   = shreg_parity;
            end
            ST_GAP:  busy_next = 1'b1;
            ST_DONE: done_next = 1'b1;
            default: ;
        endcase
    end

    // Configuration latch, counters and output registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pat_reg         <= '0;
            gap_reg         <= '0;
            frames_left_reg <= '0;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            ser_out_reg     <= 1'b0;
            ser_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            state_oh_reg    <= OH_IDLE;
        end else begin
            if ((state_reg == ST_IDLE) && (state_next == ST_SHIFT)) begin
                pat_reg         <= load_val;
                gap_reg         <= gap;
                frames_left_reg <= repeat_n;
            end else if (frame_end && (frames_left_reg != '0)) begin
                frames_left_reg <= frames_left_reg - CNT_ONE;
            end

            if (shreg_load)       bit_cnt_reg <= BIT_LAST;
            else if (shreg_shift) bit_cnt_reg <= bit_cnt_reg - BIT_ONE;

            // gap_reg is non-zero whenever GAP is entered
            if ((state_next == ST_GAP) && (state_reg != ST_GAP))
                gap_cnt_reg <= gap_reg - GAP_ONE;
            else if ((state_reg == ST_GAP) && (gap_cnt_reg != '0))
                gap_cnt_reg <= gap_cnt_reg - GAP_ONE;

            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            state_oh_reg  <= state_oh_next;
        end
    end

    assign ser_out   = ser_out_reg;
    assign ser_valid = ser_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign state_oh  = state_oh_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx.
// The stimulus side turns each accepted request into a list of timed expected
// events (pattern bits, parity bit, done pulse); the monitor compares the full
// output vector against that list on every falling edge.
module tb_seq_pattern_tx;

    localparam int PAT_W = 5;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;
    localparam logic [PAT_W-1:0] DEF_PAT = 5'b10110;
`ifdef SEQ_TX_PARITY_EN
    localparam int FL = PAT_W + 1;
`else
    localparam int FL = PAT_W;
`endif

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             start = 1'b0;
    logic             use_default = 1'b0;
    logic             abort = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             ser_out, ser_valid, busy, done;
    logic [4:0]       state_oh;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int idle_after = -1;   // last cycle in which the DUT is not IDLE
    int busy_lo = 1;
    int busy_hi = 0;

    // kind: 0 pattern bit, 1 parity bit, 2 done pulse
    typedef struct {
        int   cyc;
        int   kind;
        logic b;
    } item_t;
    item_t exp_q[$];

    seq_pattern_tx dut (
        .clk         (clk),
        .rstb        (rstb),
        .start       (start),
        .use_default (use_default),
        .pattern     (pattern),
        .repeat_n    (repeat_n),
        .gap         (gap),
        .abort       (abort),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .busy        (busy),
        .done        (done),
        .state_oh    (state_oh)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, got, exp);
        end
    endtask

    // Drop every expected event from cycle 'from' on (abort / reset).
    task automatic truncate(input int from);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= from)
            void'(exp_q.pop_back());
        if (idle_after > from - 1) idle_after = from - 1;
        if (busy_hi > from - 1) busy_hi = from - 1;
    endtask

    // Request accepted at edge e: frames start at e, spaced by frame length + gap.
    task automatic accept(input int e, input logic [PAT_W-1:0] p, input int frames, input int g);
        int base;
        int dcyc;
        for (int f = 0; f < frames; f++) begin
            base = e + f * (FL + g);
            for (int k = 0; k < PAT_W; k++)
                exp_q.push_back('{base + k, 0, p[PAT_W-1-k]});
            if (FL > PAT_W)
                exp_q.push_back('{base + PAT_W, 1, ^p});
        end
        dcyc = e + frames * FL + (frames - 1) * g;
        exp_q.push_back('{dcyc, 2, 1'b0});
        busy_lo    = e;
        busy_hi    = dcyc - 1;
        idle_after = dcyc;
    endtask

    task automatic issue(input logic s, input logic ud, input logic [PAT_W-1:0] p,
                         input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g, input logic ab);
        int e;
        @(negedge clk);
        start = s; use_default = ud; pattern = p; repeat_n = r; gap = g; abort = ab;
        e = cyc + 1;
        if (ab)
            truncate(e);
        else if (s && (e - 1 > idle_after))
            accept(e, ud ? DEF_PAT : p, int'(r) + 1, int'(g));
    endtask

    // Idle cycle with scrambled data inputs: latched config must not follow them.
    task automatic idle_cycle();
        issue(1'b0, 1'($urandom), PAT_W'($urandom), CNT_W'($urandom), GAP_W'($urandom), 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc <= idle_after + 1 && n < 600) begin
            idle_cycle();
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL wait_idle cyc=%0d got=still_busy required=idle", cyc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstb = 1'b0; start = 1'b0; abort = 1'b0;
        truncate(cyc);
        repeat (2) @(negedge clk);
        #2 rstb = 1'b1;
    endtask

    // Monitor
    initial forever begin
        logic [8:0] got, exp;
        int   kind;
        logic eb, ebusy;
        @(negedge clk);
        got = {ser_out, ser_valid, busy, done, state_oh};
        if (!rstb) begin
            check("reset", got, 9'b0_0_0_0_00001);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d got=none required_at=%0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            kind = -1;
            eb   = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                kind = exp_q[0].kind;
                eb   = exp_q[0].b;
                void'(exp_q.pop_front());
            end
            ebusy = (cyc >= busy_lo) && (cyc <= busy_hi);
            case (kind)
                0:       exp = {eb, 1'b1, ebusy, 1'b0, 5'b00010};
                1:       exp = {eb, 1'b1, ebusy, 1'b0, 5'b00100};
                2:       exp = {1'b0, 1'b0, 1'b0, 1'b1, 5'b10000};
                default: exp = ebusy ? {1'b0, 1'b0, 1'b1, 1'b0, 5'b01000}
                                     : {1'b0, 1'b0, 1'b0, 1'b0, 5'b00001};
            endcase
            check("outputs", got, exp);
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #2 rstb = 1'b1;

        // default pattern, single frame
        issue(1'b1, 1'b1, 5'b00000, 4'd0, 3'd0, 1'b0);
        wait_idle();

        // start during the DONE cycle is ignored, the next cycle is accepted
        issue(1'b1, 1'b0, 5'b01101, 4'd0, 3'd0, 1'b0);
        n = 0;
        while (cyc < idle_after - 1 && n < 100) begin
            idle_cycle();
            n++;
        end
        issue(1'b1, 1'b0, 5'b11111, 4'd0, 3'd0, 1'b0);
        issue(1'b1, 1'b0, 5'b10001, 4'd0, 3'd0, 1'b0);
        wait_idle();

        // three frames with 2-cycle gaps; starts while busy are ignored
        issue(1'b1, 1'b0, 5'b11001, 4'd2, 3'd2, 1'b0);
        for (int i = 0; i < 6; i++)
            issue(1'b1, 1'b1, PAT_W'($urandom), 4'd7, 3'd1, 1'b0);
        wait_idle();

        // abort during the third bit, then abort together with start
        issue(1'b1, 1'b1, 5'b00000, 4'd1, 3'd1, 1'b0);
        idle_cycle();
        idle_cycle();
        issue(1'b0, 1'b0, 5'b00000, 4'd0, 3'd0, 1'b1);
        idle_cycle();
        issue(1'b1, 1'b0, 5'b01010, 4'd0, 3'd0, 1'b1);
        wait_idle();

        // frame counter at its maximum, back-to-back; then the widest gap
        issue(1'b1, 1'b0, 5'b10010, 4'd15, 3'd0, 1'b0);
        wait_idle();
        issue(1'b1, 1'b0, 5'b01111, 4'd1, 3'd7, 1'b0);
        wait_idle();

        // reset in the middle of a gap, then a fresh frame
        issue(1'b1, 1'b0, 5'b10011, 4'd3, 3'd5, 1'b0);
        repeat (7) idle_cycle();
        do_reset();
        issue(1'b1, 1'b1, 5'b00000, 4'd0, 3'd0, 1'b0);
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            issue($urandom_range(0, 3) == 0, 1'($urandom), PAT_W'($urandom),
                  CNT_W'($urandom_range(0, 3)), GAP_W'($urandom), $urandom_range(0, 39) == 0);
        wait_idle();
        repeat (3) idle_cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained got=%0d_pending required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
